taillight_sequencer: RTL

//   Consumer of the divided slow clock. Runs a Thunderbird-style sequential

---
 rtl/taillight_sequencer_pkg.sv | 69 ++++++
 rtl/tick_edge_detect.sv | 31 +++
 rtl/taillight_sequencer.sv | 99 +++++++++
 3 files changed

// File: rtl/taillight_sequencer_pkg.sv
// Shared types for the taillight sequencer: FSM state and mode encodings
// plus the per-state lamp patterns.
package taillight_sequencer_pkg;

    typedef enum logic [3:0] {
        StIdle = 4'd0,
        StL1   = 4'd1,
        StL2   = 4'd2,
        StL3   = 4'd3,
        StL4   = 4'd4,
        StR1   = 4'd5,
        StR2   = 4'd6,
        StR3   = 4'd7,
        StR4   = 4'd8,
        StHon  = 4'd9,
        StHoff = 4'd10
    } state_e;

    typedef enum logic [1:0] {
        ModeNone  = 2'd0,
        ModeLeft  = 2'd1,
        ModeRight = 2'd2,
        ModeHaz   = 2'd3
    } mode_e;

    // Bank patterns, bit 0 is the innermost lamp.
    localparam logic [2:0] LampOff = 3'b000;
    localparam logic [2:0] Lamp1   = 3'b001;
    localparam logic [2:0] Lamp2   = 3'b011;
    localparam logic [2:0] Lamp3   = 3'b111;

    typedef struct packed {
        logic [2:0] left;
        logic [2:0] right;
    } lamps_t;

    function automatic lamps_t state_lamps(input state_e s);
        lamps_t l;
        l = '{left: LampOff, right: LampOff};
        unique case (s)
            StL1:    l.left  = Lamp1;
            StL2:    l.left  = Lamp2;
            StL3:    l.left  = Lamp3;
            StR1:    l.right = Lamp1;
            StR2:    l.right = Lamp2;
            StR3:    l.right = Lamp3;
            StHon:   l = '{left: Lamp3, right: Lamp3};
            default: l = '{left: LampOff, right: LampOff};
        endcase
        return l;
    endfunction

    // Hazard wins, and both turn switches together also mean hazard.
    function automatic mode_e decode_mode(input logic left, input logic right,
                                          input logic hazard);
        mode_e m;
        if (hazard || (left && right)) begin
            m = ModeHaz;
        end else if (left) begin
            m = ModeLeft;
        end else if (right) begin
            m = ModeRight;
        end else begin
            m = ModeNone;
        end
        return m;
    endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// Synchronises an asynchronous level into the in_clock domain and flags
// each of its rising edges with a one-cycle pulse.
module tick_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic in_clock,
    input  logic reset_n,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ts;
    logic                   ts_d_q;

    assign ts = sync_q[SYNC_STAGES-1];

    // Synchroniser chain plus one extra delay for edge detection.
    always_ff @(posedge in_clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            ts_d_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            ts_d_q <= ts;
        end
    end

    assign rise = ts & ~ts_d_q;

endmodule

// File: rtl/taillight_sequencer.sv
// Thunderbird-style sequential taillights on two 3-lamp banks. The slow
// divider clock is sampled as data; each of its rising edges advances the FSM.
module taillight_sequencer #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       in_clock,
    input  logic       reset_n,
    input  logic       tick_in,
    input  logic       left_req,
    input  logic       right_req,
    input  logic       hazard_req,
    output logic [2:0] lights_l,
    output logic [2:0] lights_r,
    output logic       step_out
);

    import taillight_sequencer_pkg::*;

    logic                   step;
    logic [SYNC_STAGES-1:0] left_sync_q;
    logic [SYNC_STAGES-1:0] right_sync_q;
    logic [SYNC_STAGES-1:0] hazard_sync_q;
    mode_e                  mode;
    state_e                 state_q, state_d;
    lamps_t                 lamps_q;
    logic                   step_q;

    tick_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_tick_edge (
        .in_clock (in_clock),
        .reset_n  (reset_n),
        .d        (tick_in),
        .rise     (step)
    );

    // Request switches: plain synchronisers, no debounce.
    always_ff @(posedge in_clock or negedge reset_n) begin
        if (!reset_n) begin
            left_sync_q   <= '0;
            right_sync_q  <= '0;
            hazard_sync_q <= '0;
        end else begin
            left_sync_q   <= {left_sync_q[SYNC_STAGES-2:0], left_req};
            right_sync_q  <= {right_sync_q[SYNC_STAGES-2:0], right_req};
            hazard_sync_q <= {hazard_sync_q[SYNC_STAGES-2:0], hazard_req};
        end
    end

    assign mode = decode_mode(left_sync_q[SYNC_STAGES-1], right_sync_q[SYNC_STAGES-1],
                              hazard_sync_q[SYNC_STAGES-1]);

    // Next state: only step cycles move the FSM; a mode change restarts at
    // the first state of the new sequence without finishing the old one.
    always_comb begin
        state_d = state_q;
        if (step) begin
            unique case (mode)
                ModeLeft: begin
                    case (state_q)
                        StL1:    state_d = StL2;
                        StL2:    state_d = StL3;
                        StL3:    state_d = StL4;
                        default: state_d = StL1;
                    endcase
                end
                ModeRight: begin
                    case (state_q)
                        StR1:    state_d = StR2;
                        StR2:    state_d = StR3;
                        StR3:    state_d = StR4;
                        default: state_d = StR1;
                    endcase
                end
                ModeHaz:  state_d = (state_q == StHon) ? StHoff : StHon;
                ModeNone: state_d = StIdle;
            endcase
        end
    end

    // State, lamp and probe registers; lamps decode next-state so they
    // change on the same edge as the state and never glitch.
    always_ff @(posedge in_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            lamps_q <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lamps_q <= state_lamps(state_d);
            step_q  <= step;
        end
    end

    assign lights_l = lamps_q.left;
    assign lights_r = lamps_q.right;
    assign step_out = step_q;

endmodule
